// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the state encoding, default geometry and the count-byte decoding rule.
package imem_loader_pkg;

  localparam int DEF_DEPTH      = 64;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_DATA_W     = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // A count byte of zero stands for a full memory image.
  function automatic int unsigned word_count(input logic [7:0] n, input int unsigned depth);
    return (n == 8'd0) ? depth : 32'(n);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = host/memory side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted bytes, most-significant first, into DATA_W-bit words and
// pulses word_valid for one cycle after the last byte of each word.
module byte_assembler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        byte_in,
  output logic              word_last,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0] byte_cnt;

  // High while the byte currently offered would complete a word.
  assign word_last = (byte_cnt == CNT_W'(BPW - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      byte_cnt   <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        word <= (word << 8) | DATA_W'(byte_in);
        if (word_last) begin
          byte_cnt   <= '0;
          word_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads the instruction memory from a byte stream while holding the core in reset.
// Optional trailing XOR checksum byte enabled by `define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  input  logic          start,
  output logic          cpu_reset,
  output logic          done,
  output logic          error
);

  localparam int CW = ADDR_W + 1;

  state_t            state, state_nxt;
  logic              fire;
  logic              load_byte;
  logic              word_last;
  logic              word_valid;
  logic              last_word;
  logic [DATA_W-1:0] word;
  logic [CW-1:0]     n_words;
  logic [CW-1:0]     words_seen;
  logic [ADDR_W-1:0] addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign bus.in_ready = !reset && (state == IDLE || state == LOAD || state == CHECK);
  assign fire         = bus.in_valid && bus.in_ready;
  assign load_byte    = fire && (state == LOAD);
  assign last_word    = (words_seen == n_words - CW'(1));

  assign done      = !reset && (state == DONE);
  assign error     = !reset && (state == ERROR);
  assign cpu_reset = !done;

  // The write strobe follows the assembler pulse; the address was captured
  // on the same edge that completed the word.
  assign bus.wr_en   = word_valid && !reset;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = word;

  byte_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == IDLE),
    .byte_en    (load_byte),
    .byte_in    (bus.in_data),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is given its default before the case so that no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) state_nxt = (32'(bus.in_data) > DEPTH) ? ERROR : LOAD;
      end
      LOAD: begin
        if (bus.in_valid && word_last && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (bus.in_valid) state_nxt = (bus.in_data == csum) ? DONE : ERROR;
      end
`endif
      DONE:    if (start) state_nxt = IDLE;
      ERROR:   if (start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_words    <= '0;
      words_seen <= '0;
      addr_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (state == IDLE) begin
        words_seen <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
        if (fire) n_words <= CW'(word_count(bus.in_data, DEPTH));
      end
      if (load_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ bus.in_data;
`endif
        if (word_last) begin
          words_seen <= words_seen + CW'(1);
          addr_q     <= words_seen[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus random loads with
// random in_valid gaps, compared against a stream-level reference model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW  = DEF_ADDR_W;
  localparam int DW  = DEF_DATA_W;
  localparam int DEP = DEF_DEPTH;
  localparam int BPW = BYTES_PER_WORD;

  typedef byte unsigned bq_t[$];
  typedef logic [DW-1:0] wq_t[$];
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          cr;
    logic          dn;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, done, error;

  imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  imem_loader #(.DEPTH(DEP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .start     (start),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  wr_t           obs[$];
  logic [DW-1:0] dut_img[DEP];
  logic [DW-1:0] ref_img[DEP];

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      obs.push_back('{bus.wr_addr, bus.wr_data, cpu_reset, done});
      dut_img[bus.wr_addr] = bus.wr_data;
    end
  end

  function automatic bq_t build(input int cnt, input wq_t w);
    bq_t         s;
    byte unsigned x;
    x = 8'h00;
    s.push_back(8'(cnt));
    foreach (w[i]) begin
      for (int b = BPW - 1; b >= 0; b--) begin
        s.push_back(w[i][b*8 +: 8]);
        x ^= w[i][b*8 +: 8];
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(x);
`endif
    return s;
  endfunction

  task automatic send(input byte unsigned b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("send_stall", t < 20, 1'b1);
  endtask

  // Reference: decode the stream by its format rules and compare the result.
  task automatic run_load(input string tag, input bq_t s, input int max_gap);
    int           nw, nexp, t;
    logic         bad_cnt, exp_err;
    logic [DW-1:0] w;
    obs.delete();
    nw      = (s[0] == 0) ? DEP : int'(s[0]);
    bad_cnt = nw > DEP;
    nexp    = bad_cnt ? 0 : nw;
    exp_err = bad_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!bad_cnt) begin
      byte unsigned x;
      x = 8'h00;
      for (int i = 1; i <= nw * BPW; i++) x ^= s[i];
      exp_err = (s[nw*BPW + 1] != x);
    end
`endif
    foreach (s[i]) send(s[i], $urandom_range(0, max_gap));
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (!(done || error) && t < 200) begin
      @(negedge clk);
      t++;
    end
    #1;
    check({tag, "_finish"}, t < 200, 1'b1);
    if (bad_cnt) check({tag, "_err_latency"}, t, 0);
    check({tag, "_done"}, done, !exp_err);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_cpu_reset"}, cpu_reset, exp_err);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_nwrites"}, obs.size(), nexp);
    for (int k = 0; k < nexp; k++) begin
      w = '0;
      for (int b = 0; b < BPW; b++) w = (w << 8) | DW'(s[1 + k*BPW + b]);
      ref_img[k] = w;
      if (k < obs.size()) begin
        check({tag, "_addr"}, obs[k].addr, k);
        check({tag, "_data"}, obs[k].data, w);
      end
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (nexp > 0 && obs.size() == nexp) begin
      check({tag, "_last_wr_cpu_reset"}, obs[nexp-1].cr, 1'b0);
      check({tag, "_last_wr_done"}, obs[nexp-1].dn, 1'b1);
    end
`endif
  endtask

  task automatic poke_done(input string tag);
    int n0;
    n0 = obs.size();
    repeat (4) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      #1;
      check({tag, "_rdy_in_done"}, bus.in_ready, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check({tag, "_no_extra_wr"}, obs.size(), n0);
    check({tag, "_still_done"}, done, 1'b1);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_rearm_done"}, done, 1'b0);
    check({tag, "_rearm_error"}, error, 1'b0);
    check({tag, "_rearm_cpu_reset"}, cpu_reset, 1'b1);
    check({tag, "_rearm_in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    wq_t wq;
    bq_t s;
    int  nw;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    foreach (dut_img[i]) begin
      dut_img[i] = '0;
      ref_img[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready_during", bus.in_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);

    // Basic load
    wq = {32'hDEADBEEF, 32'h01234567};
    run_load("basic", build(2, wq), 0);
    poke_done("basic");
    do_start("basic");

    // Full load
    wq.delete();
    for (int k = 0; k < DEP; k++) wq.push_back(DW'(k) * 32'h01010101);
    run_load("full", build(0, wq), 0);
    do_start("full");

    // Illegal count, then a valid load
    s = {8'h41};
    run_load("badcnt", s, 0);
    do_start("badcnt");
    wq = {32'hCAFEF00D};
    run_load("after_err", build(1, wq), 0);
    do_start("after_err");

    // Reset in the middle of a word
    obs.delete();
    send(8'h01, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_no_write", obs.size(), 0);
    check("midrst_cpu_reset", cpu_reset, 1'b1);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_done", done, 1'b0);
    wq = {32'h11223344};
    run_load("midrst_reload", build(1, wq), 0);
    do_start("midrst_reload");

    // Basic load with in_valid gaps
    wq = {32'hDEADBEEF, 32'h01234567};
    run_load("gaps", build(2, wq), 5);
    poke_done("gaps");
    do_start("gaps");

`ifdef IMEM_LOADER_CHECKSUM_EN
    s = {8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_load("csum_ok", s, 0);
    do_start("csum_ok");
    s = {8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_load("csum_bad", s, 0);
    do_start("csum_bad");
`endif

    // Random loads
    for (int r = 0; r < 4; r++) begin
      nw = $urandom_range(1, DEP);
      wq.delete();
      for (int k = 0; k < nw; k++) wq.push_back(DW'($urandom));
      run_load("rand", build((nw == DEP) ? 0 : nw, wq), 2);
      do_start("rand");
    end

    // Whole memory image, including addresses the short loads left alone
    for (int a = 0; a < DEP; a++) check("image", dut_img[a], ref_img[a]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
